pulse_conditioner: RTL and testbench

//  Front end for the pulse counting path. Takes a raw asynchronous pulse pin,

---
 rtl/pulse_pkg.sv | 28 ++
 rtl/sync_chain.sv | 38 +++
 rtl/pulse_conditioner.sv | 160 ++++++++++++++++
 tb/tb_pulse_conditioner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// ---------------------------------------------------------------------------
// pulse_pkg
//   Shared definitions for the pulse conditioning front end.
//   - state_e          : debouncer FSM states
//   - EDGE_* constants : encodings of the edge select input
//   - is_high_level()  : maps an FSM state to its debounced output level
// ---------------------------------------------------------------------------
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_QUAL = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_QUAL = 2'd3
  } state_e;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // While a falling edge is still being qualified the accepted level is
  // still high, so FALL_QUAL reports high and RISE_QUAL reports low.
  function automatic logic is_high_level(input state_e s);
    return (s == ST_HIGH) || (s == ST_FALL_QUAL);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchroniser for a single asynchronous input bit.
//   Parameters:
//     STAGES  number of flops in the chain, legal range 2..4
//   Ports:
//     clk_i   destination clock
//     rst_i   asynchronous active-high reset, clears the whole chain
//     d_i     asynchronous input
//     q_o     synchronised output (last flop of the chain)
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_chain: STAGES must be in 2..4");
  end

  logic [STAGES-1:0] chain_q;

  // Plain shift register; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// ---------------------------------------------------------------------------
// pulse_conditioner
//   Front end for the pulse counting path: synchronises a raw pulse pin,
//   rejects levels shorter than FILTER_CYCLES synced samples and emits one
//   single-cycle strobe per qualified selected edge.
//   Parameters:
//     SYNC_STAGES    synchroniser depth (2..4)
//     FILTER_CYCLES  stable synced samples needed to accept a level (>=2)
//     GLITCH_W       width of the rejected-transition counter
//   Ports:
//     clk_in          system clock
//     rst_in          asynchronous active-high reset
//     sig_in          raw pulse pin, asynchronous to clk_in
//     edge_sel_in     [0] strobe on rise, [1] strobe on fall
//     glitch_clr_in   synchronous clear of glitch_cnt_out
//     pulse_out       one-cycle strobe per qualified selected edge
//     level_out       debounced level
//     glitch_cnt_out  saturating count of rejected transitions
// ---------------------------------------------------------------------------
module pulse_conditioner
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 100,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sig_in,
  input  logic [1:0]          edge_sel_in,
  input  logic                glitch_clr_in,
  output logic                pulse_out,
  output logic                level_out,
  output logic [GLITCH_W-1:0] glitch_cnt_out
);

  if (FILTER_CYCLES < 2) begin : g_bad_filter
    $error("pulse_conditioner: FILTER_CYCLES must be >= 2");
  end

  localparam int QW = $clog2(FILTER_CYCLES);
  localparam logic [QW-1:0] QUAL_LAST = QW'(FILTER_CYCLES - 1);
  localparam logic [QW-1:0] QUAL_ONE  = QW'(1);

  logic sync;

  state_e              state_q, state_d;
  logic [QW-1:0]       qual_cnt_q, qual_cnt_d;
  logic                pulse_q, pulse_d;
  logic                level_q, level_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  logic glitch_inc;
  logic rise_acc;
  logic fall_acc;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (sig_in),
    .q_o   (sync)
  );

  // Entering a qualify state already counts the first differing sample,
  // so the counter starts at 1 and acceptance happens on the sample where
  // it already holds FILTER_CYCLES-1.
  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    glitch_inc = 1'b0;
    rise_acc   = 1'b0;
    fall_acc   = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync) begin
          state_d    = ST_RISE_QUAL;
          qual_cnt_d = QUAL_ONE;
        end
      end
      ST_RISE_QUAL: begin
        if (!sync) begin
          state_d    = ST_LOW;
          qual_cnt_d = '0;
          glitch_inc = 1'b1;
        end else if (qual_cnt_q == QUAL_LAST) begin
          state_d    = ST_HIGH;
          qual_cnt_d = '0;
          rise_acc   = 1'b1;
        end else begin
          qual_cnt_d = qual_cnt_q + QUAL_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync) begin
          state_d    = ST_FALL_QUAL;
          qual_cnt_d = QUAL_ONE;
        end
      end
      ST_FALL_QUAL: begin
        if (sync) begin
          state_d    = ST_HIGH;
          qual_cnt_d = '0;
          glitch_inc = 1'b1;
        end else if (qual_cnt_q == QUAL_LAST) begin
          state_d    = ST_LOW;
          qual_cnt_d = '0;
          fall_acc   = 1'b1;
        end else begin
          qual_cnt_d = qual_cnt_q + QUAL_ONE;
        end
      end
      default: begin
        state_d    = ST_LOW;
        qual_cnt_d = '0;
      end
    endcase
  end

  // Edge select only gates the strobe on the accepting cycle; it never
  // influences the state machine itself. Returning to the stable state
  // after a glitch is not a qualified edge and gives no strobe.
  always_comb begin
    pulse_d = (rise_acc && ((edge_sel_in & EDGE_RISE) != EDGE_NONE)) ||
              (fall_acc && ((edge_sel_in & EDGE_FALL) != EDGE_NONE));
    level_d = is_high_level(state_d);
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr_in) begin
      glitch_d = '0;
    end else if (glitch_inc && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_LOW;
      qual_cnt_q <= '0;
      pulse_q    <= 1'b0;
      level_q    <= 1'b0;
      glitch_q   <= '0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      pulse_q    <= pulse_d;
      level_q    <= level_d;
      glitch_q   <= glitch_d;
    end
  end

  assign pulse_out      = pulse_q;
  assign level_out      = level_q;
  assign glitch_cnt_out = glitch_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pulse_conditioner
//   Directed table-driven checks of pulse_conditioner with SYNC_STAGES=2,
//   FILTER_CYCLES=4, GLITCH_W=8, followed by hand-written sequences for
//   saturation/clear, reset mid-qualification and off-grid random widths.
// ---------------------------------------------------------------------------
module tb_pulse_conditioner;
  import pulse_pkg::*;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int GW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig;
  logic [1:0]    sel;
  logic          clr;
  logic          pulseOut;
  logic          levelOut;
  logic [GW-1:0] glitchOut;

  pulse_conditioner #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .GLITCH_W      (GW)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .sig_in         (sig),
    .edge_sel_in    (sel),
    .glitch_clr_in  (clr),
    .pulse_out      (pulseOut),
    .level_out      (levelOut),
    .glitch_cnt_out (glitchOut)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       sig;
    logic [1:0] sel;
    logic       clr;
    logic       pulse;
    logic       level;
    int         glitch;
    int         tag;
    int         idx;
  } vec_t;

  vec_t vecs[$];

  // Strobe monitor state for the random section
  bit monOn      = 1'b0;
  int strobeCnt  = 0;
  int cycleNo    = 0;
  int lastStrobe = -1;
  logic modelLevel;

  task automatic addVec(input logic s, input logic [1:0] es, input logic c,
                        input logic p, input logic l, input int g,
                        input int tag, input int idx);
    vec_t v;
    v.sig = s; v.sel = es; v.clr = c;
    v.pulse = p; v.level = l; v.glitch = g;
    v.tag = tag; v.idx = idx;
    vecs.push_back(v);
  endtask

  // Drive inputs just after an edge, then land 1ns after the next edge.
  task automatic applyStimulus(input logic s, input logic [1:0] es, input logic c);
    sig = s;
    sel = es;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Strobe counting and spacing check, sampled on the falling edge.
  always @(negedge clk) begin
    cycleNo++;
    if (monOn && pulseOut === 1'b1) begin
      strobeCnt++;
      if (lastStrobe >= 0) begin
        total++;
        if (cycleNo - lastStrobe < FILT) begin
          bad++;
          $display("[TB] FAIL strobe spacing: got %0d cycles required >= %0d",
                   cycleNo - lastStrobe, FILT);
        end
      end
      lastStrobe = cycleNo;
    end
  end

  // Random segments with integer-cycle widths starting off the clock grid,
  // so each segment of width w is seen as exactly w synced samples.
  task automatic runPhase(input logic [1:0] es, input int nSeg);
    int   w;
    int   expected;
    logic v;
    real  off;
    sel        = es;
    expected   = 0;
    strobeCnt  = 0;
    lastStrobe = -1;
    monOn      = 1'b1;
    @(posedge clk);
    off = real'($urandom_range(1, 8)) + 0.25;
    #(off);
    for (int i = 0; i < nSeg; i++) begin
      v   = ~sig;
      w   = int'($urandom_range(1, 20));
      sig = v;
      #(w * 10);
      if (v != modelLevel && w >= FILT) begin
        modelLevel = v;
        if (v ? es[0] : es[1]) expected++;
      end
    end
    // The final segment is held indefinitely, so it is eventually accepted.
    if (sig != modelLevel) begin
      modelLevel = sig;
      if (sig ? es[0] : es[1]) expected++;
    end
    repeat (30) @(posedge clk);
    #1;
    monOn = 1'b0;
    checkOutput($sformatf("random strobes sel=%0d", es), strobeCnt, expected);
    checkOutput($sformatf("random level sel=%0d", es), int'(levelOut), int'(modelLevel));
  endtask

  initial begin
    rst = 1'b1;
    sig = 1'b0;
    sel = EDGE_RISE;
    clr = 1'b0;

    // Test 1: clean 10-cycle pulse, rising edge only
    for (int c = 1; c <= 18; c++)
      addVec(c <= 10, EDGE_RISE, 1'b0, c == 6, (c >= 6 && c <= 15), 0, 1, c);
    // Test 2: 3-cycle glitch, then a 4-cycle pulse that is just accepted
    for (int c = 1; c <= 22; c++)
      addVec((c <= 3) || (c >= 10 && c <= 13), EDGE_RISE, 1'b0,
             c == 15, (c >= 15 && c <= 18), (c >= 6) ? 1 : 0, 2, c);
    // Test 3a: both edges, high 8 / low 8
    for (int c = 1; c <= 24; c++)
      addVec(c <= 8, EDGE_BOTH, 1'b0, (c == 6 || c == 14), (c >= 6 && c <= 13), 1, 3, c);
    // Test 3b: no edges selected, level still tracks
    for (int c = 1; c <= 24; c++)
      addVec(c <= 8, EDGE_NONE, 1'b0, 1'b0, (c >= 6 && c <= 13), 1, 4, c);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset pulse", int'(pulseOut), 0);
    checkOutput("reset level", int'(levelOut), 0);
    checkOutput("reset glitch", int'(glitchOut), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sig, vecs[i].sel, vecs[i].clr);
      checkOutput($sformatf("t%0d.%0d pulse", vecs[i].tag, vecs[i].idx),
                  int'(pulseOut), int'(vecs[i].pulse));
      checkOutput($sformatf("t%0d.%0d level", vecs[i].tag, vecs[i].idx),
                  int'(levelOut), int'(vecs[i].level));
      checkOutput($sformatf("t%0d.%0d glitch", vecs[i].tag, vecs[i].idx),
                  int'(glitchOut), vecs[i].glitch);
    end

    // Test 4: 300 three-cycle glitches saturate the counter at 255
    for (int g = 0; g < 300; g++)
      for (int c = 1; c <= 6; c++)
        applyStimulus(c <= 3, EDGE_RISE, 1'b0);
    repeat (4) applyStimulus(1'b0, EDGE_RISE, 1'b0);
    checkOutput("glitch saturated", int'(glitchOut), 255);
    checkOutput("glitch sat no strobe", int'(pulseOut), 0);
    applyStimulus(1'b0, EDGE_RISE, 1'b1);
    checkOutput("glitch clear", int'(glitchOut), 0);
    // Clear lands on the same edge as the glitch increment
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(c <= 3, EDGE_RISE, c == 6);
      if (c >= 5) checkOutput($sformatf("clr vs inc c%0d", c), int'(glitchOut), 0);
    end
    // Next glitch counts normally, exactly on its 6th edge
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(c <= 3, EDGE_RISE, 1'b0);
      if (c >= 5) checkOutput($sformatf("glitch after clr c%0d", c),
                              int'(glitchOut), (c == 6) ? 1 : 0);
    end
    repeat (3) applyStimulus(1'b0, EDGE_RISE, 1'b0);

    // Test 5: reset while RISE_QUAL has qual_cnt=2
    for (int c = 1; c <= 4; c++) applyStimulus(1'b1, EDGE_RISE, 1'b0);
    checkOutput("pre-reset glitch", int'(glitchOut), 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid-op reset pulse", int'(pulseOut), 0);
    checkOutput("mid-op reset level", int'(levelOut), 0);
    checkOutput("mid-op reset glitch", int'(glitchOut), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      applyStimulus(1'b1, EDGE_RISE, 1'b0);
      checkOutput($sformatf("post-reset pulse c%0d", c), int'(pulseOut), (c == 6) ? 1 : 0);
      checkOutput($sformatf("post-reset level c%0d", c), int'(levelOut), (c >= 6) ? 1 : 0);
    end

    // Test 6: off-grid random widths, debounced level currently high
    modelLevel = 1'b1;
    runPhase(EDGE_BOTH, 40);
    runPhase(EDGE_RISE, 40);
    runPhase(EDGE_FALL, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
